writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 135 +++++++++++++
 tb/tb_writeback_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Brief    : Commits retiring results to the scalar/vector register files with
//            write-through read bypass, CC register, busy scoreboard, R15
//            redirect pulse and a retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage #(
   parameter int NUM_VREGS  = 64,
   parameter int VREG_WIDTH = 64
) (
   input  logic                         I_CLOCK,
   input  logic                         I_RESET,
   input  logic                         I_LOCK,
   input  logic                         I_MEM_Valid,
   input  logic [7:0]                   I_Opcode,
   input  logic [15:0]                  I_PC,
   input  logic [3:0]                   I_DestRegIdx,
   input  logic [15:0]                  I_DestValue,
   input  logic [$clog2(NUM_VREGS)-1:0] I_DestVRegIdx,
   input  logic [VREG_WIDTH-1:0]        I_VecDestValue,
   input  logic [2:0]                   I_CCValue,
   input  logic                         I_RegWEn,
   input  logic                         I_VRegWEn,
   input  logic                         I_CCWEn,
   input  logic [3:0]                   I_RdIdx1,
   input  logic [3:0]                   I_RdIdx2,
   input  logic [$clog2(NUM_VREGS)-1:0] I_VRdIdx,
   input  logic                         I_SetBusyEn,
   input  logic [3:0]                   I_SetBusyIdx,
   output logic [15:0]                  O_RdData1,
   output logic [15:0]                  O_RdData2,
   output logic [VREG_WIDTH-1:0]        O_VRdData,
   output logic [2:0]                   O_CC,
   output logic [15:0]                  O_Busy,
   output logic                         O_R15Redirect,
   output logic [15:0]                  O_R15Target,
   output logic [31:0]                  O_RetireCount
);

   localparam int         c_NUM_REGS = 16;
   localparam logic [3:0] c_R15      = 4'd15;
   localparam logic [2:0] c_CC_RESET = 3'b010;

   logic [15:0]           r_rf  [c_NUM_REGS];
   logic [VREG_WIDTH-1:0] r_vrf [NUM_VREGS];
   logic [2:0]            r_cc;
   logic [15:0]           r_busy;
   logic                  r_redirect;
   logic [15:0]           r_target;
   logic [31:0]           r_retire_cnt;

   logic        w_commit;
   logic        w_rf_we;
   logic        w_vrf_we;
   logic        w_cc_we;
   logic        w_set_busy;
   logic [15:0] w_clr_mask;
   logic [15:0] w_set_mask;
   logic [15:0] w_busy_nxt;
   logic        w_unused;

   // Opcode and PC travel with the instruction but are not needed to retire it.
   assign w_unused = ^{I_Opcode, I_PC};

   assign w_commit   = I_LOCK & I_MEM_Valid & ~I_RESET;
   assign w_rf_we    = w_commit & I_RegWEn;
   assign w_vrf_we   = w_commit & I_VRegWEn;
   assign w_cc_we    = w_commit & I_CCWEn;
   assign w_set_busy = I_LOCK & I_SetBusyEn & ~I_RESET;

   // Set is applied after clear so a new producer of the same register wins.
   assign w_clr_mask = w_rf_we    ? (16'h0001 << I_DestRegIdx) : 16'h0000;
   assign w_set_mask = w_set_busy ? (16'h0001 << I_SetBusyIdx) : 16'h0000;
   assign w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;

   always_ff @(negedge I_CLOCK or posedge I_RESET) begin
      if (I_RESET) begin
         for (int i = 0; i < c_NUM_REGS; i++) begin
            r_rf[i] <= 16'h0000;
         end
      end else if (w_rf_we) begin
         r_rf[I_DestRegIdx] <= I_DestValue;
      end
   end

   always_ff @(negedge I_CLOCK or posedge I_RESET) begin
      if (I_RESET) begin
         for (int i = 0; i < NUM_VREGS; i++) begin
            r_vrf[i] <= '0;
         end
      end else if (w_vrf_we) begin
         r_vrf[I_DestVRegIdx] <= I_VecDestValue;
      end
   end

   always_ff @(negedge I_CLOCK or posedge I_RESET) begin
      if (I_RESET) begin
         r_cc         <= c_CC_RESET;
         r_busy       <= 16'h0000;
         r_redirect   <= 1'b0;
         r_target     <= 16'h0000;
         r_retire_cnt <= 32'h0000_0000;
      end else begin
         if (w_cc_we) begin
            r_cc <= I_CCValue;
         end
         if (I_LOCK) begin
            r_busy <= w_busy_nxt;
         end
         // The redirect is a single-cycle pulse, so it drops on every edge
         // that does not carry a fresh R15 write.
         r_redirect <= w_rf_we & (I_DestRegIdx == c_R15);
         if (w_rf_we && (I_DestRegIdx == c_R15)) begin
            r_target <= I_DestValue;
         end
         if (w_commit) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
         end
      end
   end

   assign O_RdData1 = (w_rf_we && (I_DestRegIdx == I_RdIdx1)) ? I_DestValue : r_rf[I_RdIdx1];
   assign O_RdData2 = (w_rf_we && (I_DestRegIdx == I_RdIdx2)) ? I_DestValue : r_rf[I_RdIdx2];
   assign O_VRdData = (w_vrf_we && (I_DestVRegIdx == I_VRdIdx)) ? I_VecDestValue : r_vrf[I_VRdIdx];

   assign O_CC          = r_cc;
   assign O_Busy        = r_busy;
   assign O_R15Redirect = r_redirect;
   assign O_R15Target   = r_target;
   assign O_RetireCount = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Brief    : Self-checking bench for writeback_stage: vector table, directed
//            corner sequences and randomized traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        I_RESET;
   logic        I_LOCK, I_MEM_Valid;
   logic [7:0]  I_Opcode;
   logic [15:0] I_PC;
   logic [3:0]  I_DestRegIdx;
   logic [15:0] I_DestValue;
   logic [5:0]  I_DestVRegIdx;
   logic [63:0] I_VecDestValue;
   logic [2:0]  I_CCValue;
   logic        I_RegWEn, I_VRegWEn, I_CCWEn;
   logic [3:0]  I_RdIdx1, I_RdIdx2;
   logic [5:0]  I_VRdIdx;
   logic        I_SetBusyEn;
   logic [3:0]  I_SetBusyIdx;
   logic [15:0] O_RdData1, O_RdData2;
   logic [63:0] O_VRdData;
   logic [2:0]  O_CC;
   logic [15:0] O_Busy;
   logic        O_R15Redirect;
   logic [15:0] O_R15Target;
   logic [31:0] O_RetireCount;

   always #5 clk = ~clk;

   writeback_stage #(.NUM_VREGS(64), .VREG_WIDTH(64)) dut (
      .I_CLOCK(clk), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_MEM_Valid(I_MEM_Valid),
      .I_Opcode(I_Opcode), .I_PC(I_PC), .I_DestRegIdx(I_DestRegIdx), .I_DestValue(I_DestValue),
      .I_DestVRegIdx(I_DestVRegIdx), .I_VecDestValue(I_VecDestValue), .I_CCValue(I_CCValue),
      .I_RegWEn(I_RegWEn), .I_VRegWEn(I_VRegWEn), .I_CCWEn(I_CCWEn),
      .I_RdIdx1(I_RdIdx1), .I_RdIdx2(I_RdIdx2), .I_VRdIdx(I_VRdIdx),
      .I_SetBusyEn(I_SetBusyEn), .I_SetBusyIdx(I_SetBusyIdx),
      .O_RdData1(O_RdData1), .O_RdData2(O_RdData2), .O_VRdData(O_VRdData), .O_CC(O_CC),
      .O_Busy(O_Busy), .O_R15Redirect(O_R15Redirect), .O_R15Target(O_R15Target),
      .O_RetireCount(O_RetireCount)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Architectural reference state
   logic [15:0] m_rf  [16];
   logic [63:0] m_vrf [64];
   logic [2:0]  m_cc;
   logic [15:0] m_busy;
   logic        m_redir;
   logic [15:0] m_tgt;
   logic [31:0] m_cnt;

   typedef struct {
      logic        lock, valid, wen;
      logic [3:0]  idx;
      logic [15:0] val;
      logic [3:0]  rd;
      logic [15:0] exp_same, exp_next;
      logic [31:0] exp_cnt;
   } vec_t;
   vec_t vecs [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
      for (int i = 0; i < 64; i++) m_vrf[i] = 64'h0;
      m_cc = 3'b010; m_busy = 16'h0; m_redir = 1'b0; m_tgt = 16'h0; m_cnt = 32'h0;
   endtask

   task automatic model_commit();
      logic c;
      if (I_RESET) begin
         model_reset();
         return;
      end
      c = I_LOCK & I_MEM_Valid;
      m_redir = c & I_RegWEn & (I_DestRegIdx == 4'd15);
      if (m_redir) m_tgt = I_DestValue;
      if (c && I_RegWEn)  begin m_rf[I_DestRegIdx] = I_DestValue; m_busy[I_DestRegIdx] = 1'b0; end
      if (c && I_VRegWEn) m_vrf[I_DestVRegIdx] = I_VecDestValue;
      if (c && I_CCWEn)   m_cc = I_CCValue;
      if (I_LOCK && I_SetBusyEn) m_busy[I_SetBusyIdx] = 1'b1;
      if (c) m_cnt = m_cnt + 1;
   endtask

   task automatic check_all(input string tag);
      logic c;
      logic [15:0] e1, e2;
      logic [63:0] ev;
      c  = I_LOCK & I_MEM_Valid & ~I_RESET;
      e1 = (c && I_RegWEn && I_DestRegIdx == I_RdIdx1) ? I_DestValue : m_rf[I_RdIdx1];
      e2 = (c && I_RegWEn && I_DestRegIdx == I_RdIdx2) ? I_DestValue : m_rf[I_RdIdx2];
      ev = (c && I_VRegWEn && I_DestVRegIdx == I_VRdIdx) ? I_VecDestValue : m_vrf[I_VRdIdx];
      check({tag, "_rd1"},   64'(O_RdData1),     64'(e1));
      check({tag, "_rd2"},   64'(O_RdData2),     64'(e2));
      check({tag, "_vrd"},   O_VRdData,          ev);
      check({tag, "_cc"},    64'(O_CC),          64'(m_cc));
      check({tag, "_busy"},  64'(O_Busy),        64'(m_busy));
      check({tag, "_redir"}, 64'(O_R15Redirect), 64'(m_redir));
      check({tag, "_tgt"},   64'(O_R15Target),   64'(m_tgt));
      check({tag, "_cnt"},   64'(O_RetireCount), 64'(m_cnt));
   endtask

   task automatic idle();
      I_LOCK = 1'b1; I_MEM_Valid = 1'b0; I_RegWEn = 1'b0; I_VRegWEn = 1'b0; I_CCWEn = 1'b0;
      I_SetBusyEn = 1'b0; I_Opcode = 8'h0; I_PC = 16'h0;
   endtask

   // Caller drives inputs just after a negedge; checks straddle the next negedge.
   task automatic step(input string tag);
      #2;
      check_all({tag, "_pre"});
      @(negedge clk);
      model_commit();
      #1;
      check_all({tag, "_post"});
   endtask

   task automatic commit_reg(input logic [3:0] idx, input logic [15:0] val);
      idle(); I_MEM_Valid = 1'b1; I_RegWEn = 1'b1; I_DestRegIdx = idx; I_DestValue = val;
   endtask

   initial begin
      idle();
      I_RESET = 1'b1;
      I_DestRegIdx = 4'd0; I_DestValue = 16'h0; I_DestVRegIdx = 6'd0; I_VecDestValue = 64'h0;
      I_CCValue = 3'b0; I_RdIdx1 = 4'd0; I_RdIdx2 = 4'd1; I_VRdIdx = 6'd0; I_SetBusyIdx = 4'd0;
      model_reset();
      #3;
      check("reset_cc", 64'(O_CC), 64'h2);
      check_all("reset");
      @(negedge clk); #1;
      I_RESET = 1'b0;

      // Scalar write / bubble table, applied straight out of reset
      vecs[0] = '{1'b1, 1'b1, 1'b1, 4'd3, 16'h1234, 4'd3, 16'h1234, 16'h1234, 32'd1};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 4'd5, 16'hBEEF, 4'd5, 16'h0000, 16'h0000, 32'd1};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 4'd5, 16'hBEEF, 4'd5, 16'h0000, 16'h0000, 32'd1};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 4'd5, 16'hBEEF, 4'd3, 16'h1234, 16'h1234, 32'd2};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 4'd3, 16'hAAAA, 4'd3, 16'hAAAA, 16'hAAAA, 32'd3};
      vecs[5] = '{1'b0, 1'b1, 1'b1, 4'd3, 16'h5555, 4'd3, 16'hAAAA, 16'hAAAA, 32'd3};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 4'd5, 16'h0001, 4'd5, 16'hBEEF, 16'hBEEF, 32'd4};
      for (int i = 0; i < 7; i++) begin
         idle();
         I_LOCK = vecs[i].lock; I_MEM_Valid = vecs[i].valid; I_RegWEn = vecs[i].wen;
         I_DestRegIdx = vecs[i].idx; I_DestValue = vecs[i].val; I_RdIdx1 = vecs[i].rd;
         #2;
         check($sformatf("vec%0d_same", i), 64'(O_RdData1), 64'(vecs[i].exp_same));
         @(negedge clk);
         model_commit();
         #1;
         check($sformatf("vec%0d_next", i), 64'(O_RdData1), 64'(vecs[i].exp_next));
         check($sformatf("vec%0d_cnt", i), 64'(O_RetireCount), 64'(vecs[i].exp_cnt));
         check_all($sformatf("vec%0d", i));
      end

      // Scoreboard set, clear, and simultaneous set+clear
      idle(); I_SetBusyEn = 1'b1; I_SetBusyIdx = 4'd7; step("busy_set");
      check("busy7_set", 64'(O_Busy[7]), 64'h1);
      commit_reg(4'd7, 16'h0707); step("busy_clr");
      check("busy7_clr", 64'(O_Busy[7]), 64'h0);
      commit_reg(4'd7, 16'h0777); I_SetBusyEn = 1'b1; I_SetBusyIdx = 4'd7; step("busy_both");
      check("busy7_both", 64'(O_Busy[7]), 64'h1);

      // R15 redirect pulse
      commit_reg(4'd15, 16'h0040); step("r15");
      check("r15_pulse", 64'(O_R15Redirect), 64'h1);
      check("r15_target", 64'(O_R15Target), 64'h0040);
      idle(); step("r15_after");
      check("r15_drop", 64'(O_R15Redirect), 64'h0);
      check("r15_hold", 64'(O_R15Target), 64'h0040);

      // Top vector register, and CC has no bypass
      idle(); I_MEM_Valid = 1'b1; I_VRegWEn = 1'b1; I_DestVRegIdx = 6'd63;
      I_VecDestValue = 64'h0001_0002_0003_0004; I_VRdIdx = 6'd63;
      I_CCWEn = 1'b1; I_CCValue = 3'b101;
      #2;
      check("vreg63_bypass", O_VRdData, 64'h0001_0002_0003_0004);
      check("cc_nobypass", 64'(O_CC), 64'h2);
      @(negedge clk); model_commit(); #1;
      check("vreg63_rf", O_VRdData, 64'h0001_0002_0003_0004);
      check("cc_written", 64'(O_CC), 64'h5);
      check_all("vreg");

      // Counter wrap
      idle();
      force dut.r_retire_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.r_retire_cnt;
      m_cnt = 32'hFFFF_FFFF;
      I_MEM_Valid = 1'b1; step("wrap");
      check("cnt_wrap", 64'(O_RetireCount), 64'h0);

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         idle();
         I_LOCK         = ($urandom_range(7, 0) != 0);
         I_MEM_Valid    = ($urandom_range(3, 0) != 0);
         I_RegWEn       = 1'($urandom);
         I_VRegWEn      = 1'($urandom);
         I_CCWEn        = 1'($urandom);
         I_DestRegIdx   = 4'($urandom);
         I_DestValue    = 16'($urandom);
         I_DestVRegIdx  = 6'($urandom);
         I_VecDestValue = {$urandom, $urandom};
         I_CCValue      = 3'($urandom);
         I_RdIdx1       = ($urandom_range(1, 0) != 0) ? I_DestRegIdx : 4'($urandom);
         I_RdIdx2       = 4'($urandom);
         I_VRdIdx       = ($urandom_range(1, 0) != 0) ? I_DestVRegIdx : 6'($urandom);
         I_SetBusyEn    = 1'($urandom);
         I_SetBusyIdx   = ($urandom_range(3, 0) == 0) ? I_DestRegIdx : 4'($urandom);
         I_Opcode       = 8'($urandom);
         I_PC           = 16'($urandom);
         step("rnd");
      end

      // Asynchronous reset in the middle of a pending commit
      commit_reg(4'd3, 16'h9999); I_RdIdx1 = 4'd3; I_SetBusyEn = 1'b1; I_SetBusyIdx = 4'd2;
      #2;
      I_RESET = 1'b1;
      #1;
      model_reset();
      check("arst_cc", 64'(O_CC), 64'h2);
      check("arst_cnt", 64'(O_RetireCount), 64'h0);
      check("arst_rd1", 64'(O_RdData1), 64'h0);
      check_all("arst");
      @(negedge clk); model_commit(); #1;
      check_all("arst_edge");
      I_RESET = 1'b0;
      step("first_commit");
      check("first_cnt", 64'(O_RetireCount), 64'h1);
      check("first_rd1", 64'(O_RdData1), 64'h9999);
      check("first_busy", 64'(O_Busy), 64'h0004);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
